// File: rtl/rv_seq_pkg.sv
// Shared types and constants for the multi-cycle RV32 sequencer: state encodings,
// supported opcodes, output strobe bundle and wait-timer sizing.
package rv_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic       instr_mem_read;
    logic       ir_write;
    logic       data_mem_read;
    logic [3:0] data_mem_write;
    logic       rd_write;
    logic       pc_write;
  } seq_strobes_t;

  // Counter must hold the value MEM_TIMEOUT itself; keep at least one bit.
  function automatic int unsigned wait_timer_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic logic opcode_supported(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI,
      OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR: opcode_supported = 1'b1;
      default:                                  opcode_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder / memory-port / write-enable bundle between the sequencer (master)
// and the surrounding datapath (slave).
interface multicycle_sequencer_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [6:0]       opcode;
  logic             dec_data_mem_read;
  logic [3:0]       dec_data_mem_write;
  logic             dec_rd_write;
  logic             mem_ready;
  logic             halt_req;

  logic             instr_mem_read;
  logic             ir_write;
  logic             data_mem_read;
  logic [3:0]       data_mem_write;
  logic             rd_write;
  logic             pc_write;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, dec_data_mem_read, dec_data_mem_write, dec_rd_write,
           mem_ready, halt_req,
    output instr_mem_read, ir_write, data_mem_read, data_mem_write,
           rd_write, pc_write, state, halted, illegal, bus_err, instret
  );

  modport slave (
    output opcode, dec_data_mem_read, dec_data_mem_write, dec_rd_write,
           mem_ready, halt_req,
    input  instr_mem_read, ir_write, data_mem_read, data_mem_write,
           rd_write, pc_write, state, halted, illegal, bus_err, instret
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Per-request memory wait counter: counts enabled cycles, saturates at
// MEM_TIMEOUT and flags expiry; MEM_TIMEOUT of 0 never expires.
module seq_wait_timer
  import rv_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = wait_timer_w(MEM_TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TW'(1);
    end
  end

  always_comb begin
    expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// memory wait timeout, halt and fault reporting. Define MULTICYCLE_SEQ_INSTRET_EN
// to build the retired-instruction counter; otherwise instret is tied to 0.
module multicycle_sequencer
  import rv_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  seq_state_e   state_q;
  seq_state_e   state_d;
  seq_strobes_t strb;
  logic         halt_pend_q;
  logic         illegal_q;
  logic         bus_err_q;
  logic         expired;
  logic         in_wait_c;

  assign in_wait_c = (state_q == ST_FETCH) || (state_q == ST_MEM);

  seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d != state_q),
    .en      (in_wait_c && !bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a ready memory beats an expired timer in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  state_d = ST_DECODE;
        else if (expired)   state_d = ST_HALT;
      end
      ST_DECODE: state_d = opcode_supported(bus.opcode) ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        state_d = (bus.dec_data_mem_read || (|bus.dec_data_mem_write)) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ready)  state_d = ST_WB;
        else if (expired)   state_d = ST_HALT;
      end
      ST_WB:     state_d = halt_pend_q ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Strobes follow only the registered state and timer; requests never see mem_ready.
  always_comb begin
    strb = '0;
    case (state_q)
      ST_FETCH: begin
        strb.instr_mem_read = !expired;
        strb.ir_write       = bus.mem_ready;
      end
      ST_MEM: begin
        if (!expired) begin
          strb.data_mem_read  = bus.dec_data_mem_read;
          strb.data_mem_write = bus.dec_data_mem_write;
        end
      end
      ST_WB: begin
        strb.rd_write = bus.dec_rd_write;
        strb.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      halt_pend_q <= halt_pend_q | bus.halt_req;
      if ((state_q == ST_DECODE) && !opcode_supported(bus.opcode)) begin
        illegal_q <= 1'b1;
      end
      if (in_wait_c && expired && !bus.mem_ready) begin
        bus_err_q <= 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_SEQ_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (state_q == ST_WB) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif

  assign bus.instr_mem_read = strb.instr_mem_read;
  assign bus.ir_write       = strb.ir_write;
  assign bus.data_mem_read  = strb.data_mem_read;
  assign bus.data_mem_write = strb.data_mem_write;
  assign bus.rd_write       = strb.rd_write;
  assign bus.pc_write       = strb.pc_write;
  assign bus.state          = state_q;
  assign bus.halted         = (state_q == ST_HALT);
  assign bus.illegal        = illegal_q;
  assign bus.bus_err        = bus_err_q;

endmodule
